// File: rtl/spi_master_arb_if.sv
// spi_master_arb_if: requester handshake, response and spi_master-facing bus of
// spi_master_arb. The "master" modport is the arbiter's view; the "slave" modport
// is the view of the requesters plus the spi_master instance.
interface spi_master_arb_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 2
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_read;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ack;
  logic [NREQ-1:0]            rsp_done;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic                       rsp_err;
  logic                       busy;
  logic                       spi_start;
  logic                       spi_read;
  logic [ADDR_WIDTH-1:0]      spi_addr;
  logic [DATA_WIDTH-1:0]      spi_data;
  logic                       spi_cs_n;
  logic                       spi_ready;
  logic [DATA_WIDTH-1:0]      spi_rdbk;

  modport master (
    input  req_valid, req_read, req_addr, req_data,
    input  spi_cs_n, spi_ready, spi_rdbk,
    output req_ack, rsp_done, rsp_data, rsp_err, busy,
    output spi_start, spi_read, spi_addr, spi_data
  );

  modport slave (
    output req_valid, req_read, req_addr, req_data,
    output spi_cs_n, spi_ready, spi_rdbk,
    input  req_ack, rsp_done, rsp_data, rsp_err, busy,
    input  spi_start, spi_read, spi_addr, spi_data
  );
endinterface

// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin arbiter and sequencer sharing one spi_master among
// NREQ requesters. Latches the winning request, drives spi_start, follows the
// master's chip select and returns read-back data with a per-requester done pulse.
// Optional feature: define SPI_MASTER_ARB_TIMEOUT_EN to add a chip-select watchdog
// in WAIT_CS (TIMEOUT_CYCLES); without it WAIT_CS waits indefinitely.
module spi_master_arb #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int NREQ           = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int RDBK_WAIT      = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_arb_if.master bus
);

  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC_A = (GAP_CYCLES > RDBK_WAIT) ? GAP_CYCLES : RDBK_WAIT;
  localparam int MAXC_B = (MAXC_A > TIMEOUT_CYCLES) ? MAXC_A : TIMEOUT_CYCLES;
  localparam int MAXC   = (MAXC_B > 2) ? MAXC_B : 2;
  localparam int CW     = $clog2(MAXC + 1);

  // START spans three state cycles so spi_start (registered) is high for two of them
  localparam logic [CW-1:0] START_LAST = CW'(2);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] RDBK_LAST  = CW'((RDBK_WAIT > 1) ? RDBK_WAIT - 1 : 0);
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST   = CW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_CS,
    ACTIVE,
    POST,
    GAP
  } state_t;

  state_t                state;
  logic [IW-1:0]         ptr;
  logic [NREQ-1:0]       owner;
  logic [CW-1:0]         cnt;
  logic                  rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  start_q;
  logic [NREQ-1:0]       ack_q;
  logic [NREQ-1:0]       done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  busy_q;

  logic                  win_found;
  logic [IW-1:0]         win;
  logic [IW-1:0]         next_ptr;
  logic [NREQ-1:0]       win_oh;
  logic                  sel_read;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  int unsigned           idx;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Round-robin search: first set req_valid from ptr upward, wrapping modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && bus.req_valid[IW'(idx)]) begin
        win_found = 1'b1;
        win       = IW'(idx);
      end
    end
  end

  // Winner one-hot, wrapped next pointer and the winner's request fields
  always_comb begin
    win_oh   = '0;
    sel_read = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    next_ptr = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        win_oh[i] = 1'b1;
        sel_read  = bus.req_read[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            ack_q  <= win_oh;
            owner  <= win_oh;
            rd_q   <= sel_read;
            addr_q <= sel_addr;
            data_q <= sel_data;
            ptr    <= next_ptr;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          start_q <= 1'b1;
          if (cnt == START_LAST) begin
            cnt   <= '0;
            state <= WAIT_CS;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        WAIT_CS: begin
          if (!bus.spi_cs_n) begin
            start_q <= 1'b0;
            state   <= ACTIVE;
          end
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
          else if (cnt == TMO_LAST) begin
            start_q <= 1'b0;
            done_q  <= owner;
            err_q   <= 1'b1;
            rdata_q <= '0;
            cnt     <= '0;
            state   <= GAP;
          end else begin
            cnt <= sat_inc(cnt);
          end
`endif
        end
        ACTIVE: begin
          if (bus.spi_cs_n) begin
            cnt   <= '0;
            state <= POST;
          end
        end
        POST: begin
          if (!rd_q) begin
            done_q  <= owner;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
            state   <= GAP;
          end else if (bus.spi_ready) begin
            done_q  <= owner;
            err_q   <= 1'b0;
            rdata_q <= bus.spi_rdbk;
            cnt     <= '0;
            state   <= GAP;
          end else if (cnt == RDBK_LAST) begin
            done_q  <= owner;
            err_q   <= 1'b1;
            rdata_q <= '0;
            cnt     <= '0;
            state   <= GAP;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        GAP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (cnt == GAP_LAST) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.rsp_done  = done_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = busy_q;
  assign bus.spi_start = start_q;
  assign bus.spi_read  = rd_q;
  assign bus.spi_addr  = addr_q;
  assign bus.spi_data  = data_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: scoreboard bench for spi_master_arb with a behavioural
// spi_master model. Build with SPI_MASTER_ARB_TIMEOUT_EN to cover the watchdog.
module tb_spi_master_arb;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int NR  = 2;
  localparam int GAP = 4;
  localparam int RW  = 7;
  localparam int TO  = 255;

  typedef struct {
    int            req;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
    logic          err;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_master_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) bus ();

  spi_master_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR),
    .GAP_CYCLES(GAP), .RDBK_WAIT(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_ack_q[$];
  txn_t exp_spi_q[$];
  txn_t exp_rsp_q[$];

  logic          hang          = 1'b0;
  logic          ready_en      = 1'b1;
  logic          glitch        = 1'b0;
  logic          expect_glitch = 1'b0;
  logic [DW-1:0] rdbk_val      = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // spi_master model: cs low 6 cycles, 3 cycles after a start rise; optional read strobe
  logic [2:0] m_ph;
  logic [3:0] m_cnt;
  logic       start_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.spi_cs_n  <= 1'b1;
      bus.spi_ready <= 1'b0;
      bus.spi_rdbk  <= '0;
      m_ph          <= '0;
      m_cnt         <= '0;
      start_d       <= 1'b0;
    end else begin
      start_d       <= bus.spi_start;
      bus.spi_ready <= 1'b0;
      case (m_ph)
        3'd0: begin
          if (glitch) begin
            bus.spi_cs_n  <= 1'b0;
            bus.spi_ready <= 1'b1;
            bus.spi_rdbk  <= 8'hEE;
            m_ph          <= 3'd4;
          end else if (bus.spi_start && !start_d && !hang) begin
            m_cnt <= '0;
            m_ph  <= 3'd1;
          end
        end
        3'd1: if (m_cnt == 4'd2) begin bus.spi_cs_n <= 1'b0; m_cnt <= '0; m_ph <= 3'd2; end
              else m_cnt <= m_cnt + 4'd1;
        3'd2: if (m_cnt == 4'd5) begin bus.spi_cs_n <= 1'b1; m_cnt <= '0; m_ph <= 3'd3; end
              else m_cnt <= m_cnt + 4'd1;
        3'd3: if (m_cnt == 4'd1) begin
                if (bus.spi_read && ready_en) begin
                  bus.spi_ready <= 1'b1;
                  bus.spi_rdbk  <= rdbk_val;
                end
                m_ph <= 3'd0;
              end else m_cnt <= m_cnt + 4'd1;
        default: begin bus.spi_cs_n <= 1'b1; m_ph <= 3'd0; end
      endcase
    end
  end

  // Output monitor: ack order/latency, start gap, SPI fields, responses
  int            low_cnt;
  bit            have_prev, start_prev, cs_prev, ack_d, spi_track;
  logic [AW-1:0] cur_addr;
  initial begin
    txn_t mt;
    int   mr;
    low_cnt = 0; have_prev = 0; start_prev = 0; cs_prev = 1; ack_d = 0; spi_track = 0;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 0; start_prev = 0; cs_prev = 1; ack_d = 0; spi_track = 0; low_cnt = 0;
      end else begin
        if (ack_d) check("ack_to_start", bus.spi_start, 1);
        ack_d = 0;
        if (bus.req_ack != '0) begin
          check("ack_start_low", bus.spi_start, 0);
          if (exp_ack_q.size() == 0) check("ack_unexp", bus.req_ack, 0);
          else begin
            mr = exp_ack_q.pop_front();
            check("ack_order", bus.req_ack, 1 << mr);
          end
          ack_d = 1;
        end
        if (bus.spi_start && !start_prev) begin
          if (have_prev) check("start_gap_ge4", low_cnt >= GAP, 1);
          have_prev = 1;
          low_cnt   = 0;
        end else if (!bus.spi_start) low_cnt++;
        start_prev = bus.spi_start;
        if (cs_prev && !bus.spi_cs_n && !expect_glitch) begin
          if (exp_spi_q.size() == 0) check("spi_unexp", exp_spi_q.size(), 1);
          else begin
            mt = exp_spi_q.pop_front();
            check("spi_addr", bus.spi_addr, mt.addr);
            check("spi_data", bus.spi_data, mt.data);
            check("spi_read", bus.spi_read, mt.rd);
            cur_addr  = mt.addr;
            spi_track = 1;
          end
        end else if (!bus.spi_cs_n && spi_track) begin
          check("addr_stable", bus.spi_addr, cur_addr);
        end
        if (bus.spi_cs_n) spi_track = 0;
        cs_prev = bus.spi_cs_n;
        if (bus.rsp_done != '0) begin
          check("done_onehot", $onehot(bus.rsp_done), 1);
          if (exp_rsp_q.size() == 0) check("done_unexp", bus.rsp_done, 0);
          else begin
            mt = exp_rsp_q.pop_front();
            check("done_who", bus.rsp_done, 1 << mt.req);
            if (mt.rd) check("done_data", bus.rsp_data, mt.rdata);
            check("done_err", bus.rsp_err, mt.err);
          end
        end
      end
    end
  end

  task automatic push_txn(input int r, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] rdv,
                          input logic err, input bit spi);
    txn_t t;
    t.req = r; t.rd = rd; t.addr = a; t.data = d; t.rdata = rdv; t.err = err;
    if (spi) exp_spi_q.push_back(t);
    exp_rsp_q.push_back(t);
  endtask

  task automatic set_req(input int r, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_read[r]           = rd;
    bus.req_addr[r*AW +: AW]  = a;
    bus.req_data[r*DW +: DW]  = d;
    bus.req_valid[r]          = 1'b1;
  endtask

  task automatic send(input int r, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_ack_q.push_back(r);
    set_req(r, rd, a, d);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ack[r]) break;
    end
    if (!bus.req_ack[r]) check("ack_timeout", bus.req_ack, 1 << r);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_rsp_q.size() == 0 && !bus.busy) break;
      @(negedge clk);
    end
    if (exp_rsp_q.size() != 0 || bus.busy) check("wait_idle", exp_rsp_q.size() + 32'(bus.busy), 0);
  endtask

  task automatic wait_cs(input logic lvl);
    for (int i = 0; i < 100; i++) begin
      if (bus.spi_cs_n == lvl) break;
      @(negedge clk);
    end
    if (bus.spi_cs_n != lvl) check("cs_wait", bus.spi_cs_n, lvl);
  endtask

  task automatic cycles_to_done(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (bus.rsp_done != '0) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int kc[NR];
    int acks;
    bus.req_valid = '0;
    bus.req_read  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {bus.req_ack, bus.rsp_done, bus.rsp_data, bus.rsp_err, bus.busy,
                      bus.spi_start, bus.spi_read}, 0);
    check("rst_bus", {bus.spi_addr, bus.spi_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write from requester 0, done two cycles after cs release
    push_txn(0, 1'b0, 16'h0012, 8'hA5, 8'h00, 1'b0, 1);
    send(0, 1'b0, 16'h0012, 8'hA5);
    wait_cs(1'b0);
    wait_cs(1'b1);
    cycles_to_done(n);
    check("wr_done_lat", n, 2);
    wait_idle(100);

    // Read from requester 1 with read strobe
    rdbk_val = 8'h5C;
    push_txn(1, 1'b1, 16'h8034, 8'h00, 8'h5C, 1'b0, 1);
    send(1, 1'b1, 16'h8034, 8'h00);
    wait_idle(100);

    // cs glitch and stray spi_ready while idle must be ignored
    expect_glitch = 1'b1;
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", bus.busy, 0);
    expect_glitch = 1'b0;

    // Contention: both requesters hold valid for four writes each
    for (int k = 0; k < 4; k++) for (int r = 0; r < NR; r++) exp_ack_q.push_back(r);
    for (int r = 0; r < NR; r++) begin
      kc[r] = 0;
      push_txn(r, 1'b0, 16'h1000 + 16'(r * 256), 8'h10 * 8'(r), 8'h00, 1'b0, 1);
      set_req(r, 1'b0, 16'h1000 + 16'(r * 256), 8'h10 * 8'(r));
    end
    acks = 0;
    for (int g = 0; g < 2000 && acks < 8; g++) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (bus.req_ack[r]) begin
          acks++;
          kc[r]++;
          if (kc[r] < 4) begin
            push_txn(r, 1'b0, 16'h1000 + 16'(r * 256 + kc[r]), 8'h10 * 8'(r) + 8'(kc[r]),
                     8'h00, 1'b0, 1);
            set_req(r, 1'b0, 16'h1000 + 16'(r * 256 + kc[r]), 8'h10 * 8'(r) + 8'(kc[r]));
          end else begin
            bus.req_valid[r] = 1'b0;
          end
        end
      end
    end
    check("cont_acks", acks, 8);
    wait_idle(200);

    // Read with no strobe: error after RDBK_WAIT POST cycles
    ready_en = 1'b0;
    push_txn(0, 1'b1, 16'h00F0, 8'h00, 8'h00, 1'b1, 1);
    send(0, 1'b1, 16'h00F0, 8'h00);
    wait_cs(1'b0);
    wait_cs(1'b1);
    cycles_to_done(n);
    check("rdbk_tmo_lat", n, RW + 1);
    wait_idle(100);
    ready_en = 1'b1;

    // chip select never asserts
    hang = 1'b1;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
    push_txn(0, 1'b1, 16'h0BAD, 8'h00, 8'h00, 1'b1, 0);
    send(0, 1'b1, 16'h0BAD, 8'h00);
    cycles_to_done(n);
    check("cs_tmo_lat", n, TO + 3);
    wait_idle(100);
    check("cs_tmo_idle", bus.busy, 0);
`else
    send(0, 1'b1, 16'h0BAD, 8'h00);
    repeat (300) @(negedge clk);
    check("hang_busy", bus.busy, 1);
    check("hang_start", bus.spi_start, 1);
`endif
    hang = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_recover", {bus.busy, bus.spi_start}, 0);
    exp_ack_q.delete();
    exp_spi_q.delete();
    exp_rsp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-ACTIVE: outputs clear at once, pending requester 1 wins afterwards
    push_txn(0, 1'b0, 16'h0ABC, 8'h3C, 8'h00, 1'b0, 1);
    send(0, 1'b0, 16'h0ABC, 8'h3C);
    wait_cs(1'b0);
    @(negedge clk);
    set_req(1, 1'b1, 16'h0777, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", {bus.req_ack, bus.rsp_done, bus.rsp_data, bus.rsp_err, bus.busy,
                          bus.spi_start, bus.spi_read}, 0);
    check("rst_mid_bus", {bus.spi_addr, bus.spi_data}, 0);
    exp_ack_q.delete();
    exp_spi_q.delete();
    exp_rsp_q.delete();
    rdbk_val = 8'h9D;
    exp_ack_q.push_back(1);
    push_txn(1, 1'b1, 16'h0777, 8'h00, 8'h9D, 1'b0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ack[1]) break;
    end
    check("rst_first_ack", bus.req_ack, 2'b10);
    bus.req_valid[1] = 1'b0;
    wait_idle(100);

    repeat (5) @(negedge clk);
    check("queues_empty", exp_ack_q.size() + exp_spi_q.size() + exp_rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
